toy_bus_dec_node_ack_2out: RTL and testbench

- Split node for the ToyBusAck payload channel: one upstream input, two downstream outputs, steered by tgt_id.
- It is the mirror of the 2:1 age-matrix arbitration node and sits at the fan-out side of the dmem ack network.
- Each output has a 2-entry registered buffer, so out*_rdy never reaches in_rdy combinationally.
- Unroutable beats are absorbed, counted and flagged.

---
 rtl/toy_bus_pkg.sv | 34 +++
 rtl/toy_bus_skid_fifo2.sv | 60 ++++++
 rtl/toy_bus_dec_node_ack_2out.sv | 163 ++++++++++++++++
 tb/tb_toy_bus_dec_node_ack_2out.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_bus_pkg.sv
// Shared ToyBusAck definitions: field widths, node target ids and the ack payload struct.
package toy_bus_pkg;

    localparam int unsigned ACK_OPCODE_W = 1;
    localparam int unsigned ACK_DATA_W   = 256;
    localparam int unsigned ACK_SB_W     = 10;
    localparam int unsigned ACK_ID_W     = 4;

    localparam logic [ACK_ID_W-1:0] NODE_ID_DMEM0 = 4'd0;
    localparam logic [ACK_ID_W-1:0] NODE_ID_DMEM1 = 4'd1;

    typedef struct packed {
        logic [ACK_OPCODE_W-1:0] opcode;
        logic [ACK_DATA_W-1:0]   data;
        logic [ACK_SB_W-1:0]     sideband;
        logic [ACK_ID_W-1:0]     src_id;
        logic [ACK_ID_W-1:0]     tgt_id;
    } toy_bus_ack_t;

    // Occupancy update for a 2-entry buffer; a push when full is never issued.
    function automatic logic [1:0] fifo2_count_next(input logic [1:0] count,
                                                    input logic       push,
                                                    input logic       pop);
        logic [1:0] nxt;
        nxt = count;
        if (push && !pop) begin
            nxt = count + 2'd1;
        end else if (pop && !push) begin
            nxt = count - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/toy_bus_skid_fifo2.sv
// Two-entry registered payload buffer; head output is forced to zero while empty.
module toy_bus_skid_fifo2
    import toy_bus_pkg::*;
#(
    parameter type entry_t = toy_bus_ack_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t wr_data,
    input  logic   rdy,
    output logic   full,
    output logic   vld,
    output entry_t rd_data
);

    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, rd_ptr_q;
    logic       push_en, pop_en;
    entry_t     mem_q [2];

    assign full    = (count_q == 2'd2);
    assign vld     = (count_q != 2'd0);
    assign push_en = push & ~full;
    assign pop_en  = vld & rdy;
    assign count_d = fifo2_count_next(count_q, push_en, pop_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push_en) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_en) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Storage is not reset; the vld gate below keeps the head at zero after reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (vld) begin
            rd_data = mem_q[rd_ptr_q];
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/toy_bus_dec_node_ack_2out.sv
// 1:2 split node for the ToyBusAck channel: routes by tgt_id into two 2-entry buffers,
// absorbing and recording beats whose tgt_id matches neither output.
module toy_bus_dec_node_ack_2out
    import toy_bus_pkg::*;
#(
    parameter int unsigned    DATA_W  = ACK_DATA_W,
    parameter int unsigned    SB_W    = ACK_SB_W,
    parameter int unsigned    ID_W    = ACK_ID_W,
    parameter logic [ID_W-1:0] OUT0_ID = NODE_ID_DMEM0,
    parameter logic [ID_W-1:0] OUT1_ID = NODE_ID_DMEM1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_vld,
    output logic              in_rdy,
    input  logic              in_opcode,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SB_W-1:0]   in_sideband,
    input  logic [ID_W-1:0]   in_src_id,
    input  logic [ID_W-1:0]   in_tgt_id,

    output logic              out0_vld,
    input  logic              out0_rdy,
    output logic              out0_opcode,
    output logic [DATA_W-1:0] out0_data,
    output logic [SB_W-1:0]   out0_sideband,
    output logic [ID_W-1:0]   out0_src_id,
    output logic [ID_W-1:0]   out0_tgt_id,

    output logic              out1_vld,
    input  logic              out1_rdy,
    output logic              out1_opcode,
    output logic [DATA_W-1:0] out1_data,
    output logic [SB_W-1:0]   out1_sideband,
    output logic [ID_W-1:0]   out1_src_id,
    output logic [ID_W-1:0]   out1_tgt_id,

    output logic [7:0]        drop_cnt,
    output logic              err_vld,
    output logic [ID_W-1:0]   err_src_id,
    output logic [ID_W-1:0]   err_tgt_id,
    input  logic              err_clr
);

    typedef struct packed {
        logic              opcode;
        logic [DATA_W-1:0] data;
        logic [SB_W-1:0]   sideband;
        logic [ID_W-1:0]   src_id;
        logic [ID_W-1:0]   tgt_id;
    } ack_t;

    logic sel0, sel1, seld;
    logic full0, full1;
    logic push0, push1, drop;
    ack_t in_beat, head0, head1;

    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic            err_vld_q, err_vld_d;
    logic [ID_W-1:0] err_src_q, err_src_d;
    logic [ID_W-1:0] err_tgt_q, err_tgt_d;

    assign sel0 = (in_tgt_id == OUT0_ID);
    assign sel1 = (in_tgt_id == OUT1_ID);
    assign seld = ~sel0 & ~sel1;

    // Only decode and registered fullness feed in_rdy, so downstream ready never reaches it.
    assign in_rdy = (sel0 & ~full0) | (sel1 & ~full1) | seld;

    assign push0 = in_vld & in_rdy & sel0;
    assign push1 = in_vld & in_rdy & sel1;
    assign drop  = in_vld & in_rdy & seld;

    assign in_beat = '{opcode:   in_opcode,
                       data:     in_data,
                       sideband: in_sideband,
                       src_id:   in_src_id,
                       tgt_id:   in_tgt_id};

    toy_bus_skid_fifo2 #(
        .entry_t (ack_t)
    ) u_buf0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push0),
        .wr_data (in_beat),
        .rdy     (out0_rdy),
        .full    (full0),
        .vld     (out0_vld),
        .rd_data (head0)
    );

    toy_bus_skid_fifo2 #(
        .entry_t (ack_t)
    ) u_buf1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push1),
        .wr_data (in_beat),
        .rdy     (out1_rdy),
        .full    (full1),
        .vld     (out1_vld),
        .rd_data (head1)
    );

    assign out0_opcode   = head0.opcode;
    assign out0_data     = head0.data;
    assign out0_sideband = head0.sideband;
    assign out0_src_id   = head0.src_id;
    assign out0_tgt_id   = head0.tgt_id;

    assign out1_opcode   = head1.opcode;
    assign out1_data     = head1.data;
    assign out1_sideband = head1.sideband;
    assign out1_src_id   = head1.src_id;
    assign out1_tgt_id   = head1.tgt_id;

    // A drop in the same cycle as err_clr wins: it restarts the count and recaptures ids.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        err_vld_d  = err_vld_q;
        err_src_d  = err_src_q;
        err_tgt_d  = err_tgt_q;
        if (drop) begin
            if (err_clr) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
            if (!err_vld_q || err_clr) begin
                err_vld_d = 1'b1;
                err_src_d = in_src_id;
                err_tgt_d = in_tgt_id;
            end
        end else if (err_clr) begin
            drop_cnt_d = 8'd0;
            err_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 8'd0;
            err_vld_q  <= 1'b0;
            err_src_q  <= '0;
            err_tgt_q  <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            err_vld_q  <= err_vld_d;
            err_src_q  <= err_src_d;
            err_tgt_q  <= err_tgt_d;
        end
    end

    assign drop_cnt   = drop_cnt_q;
    assign err_vld    = err_vld_q;
    assign err_src_id = err_src_q;
    assign err_tgt_id = err_tgt_q;

    assert property (@(posedge clk) disable iff (!rst_n) !(sel0 && sel1));

endmodule

// File: tb/tb_toy_bus_dec_node_ack_2out.sv
// Scoreboard bench for the 1:2 ack split node: stimulus pushes expected beats, a monitor pops them.
module tb_toy_bus_dec_node_ack_2out;

    localparam int PW = 1 + 256 + 10 + 4 + 4;
    typedef logic [PW-1:0] beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_vld, in_rdy, in_opcode;
    logic [255:0] in_data;
    logic [9:0]   in_sideband;
    logic [3:0]   in_src_id, in_tgt_id;
    logic         out0_vld, out0_rdy, out0_opcode;
    logic [255:0] out0_data;
    logic [9:0]   out0_sideband;
    logic [3:0]   out0_src_id, out0_tgt_id;
    logic         out1_vld, out1_rdy, out1_opcode;
    logic [255:0] out1_data;
    logic [9:0]   out1_sideband;
    logic [3:0]   out1_src_id, out1_tgt_id;
    logic [7:0]   drop_cnt;
    logic         err_vld, err_clr;
    logic [3:0]   err_src_id, err_tgt_id;

    int    n_vec  = 0;
    int    n_fail = 0;
    int    cyc    = 0;
    beat_t q0[$];
    beat_t q1[$];

    toy_bus_dec_node_ack_2out dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_vld        (in_vld),
        .in_rdy        (in_rdy),
        .in_opcode     (in_opcode),
        .in_data       (in_data),
        .in_sideband   (in_sideband),
        .in_src_id     (in_src_id),
        .in_tgt_id     (in_tgt_id),
        .out0_vld      (out0_vld),
        .out0_rdy      (out0_rdy),
        .out0_opcode   (out0_opcode),
        .out0_data     (out0_data),
        .out0_sideband (out0_sideband),
        .out0_src_id   (out0_src_id),
        .out0_tgt_id   (out0_tgt_id),
        .out1_vld      (out1_vld),
        .out1_rdy      (out1_rdy),
        .out1_opcode   (out1_opcode),
        .out1_data     (out1_data),
        .out1_sideband (out1_sideband),
        .out1_src_id   (out1_src_id),
        .out1_tgt_id   (out1_tgt_id),
        .drop_cnt      (drop_cnt),
        .err_vld       (err_vld),
        .err_src_id    (err_src_id),
        .err_tgt_id    (err_tgt_id),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [299:0] got, input logic [299:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Monitor: a handshake at the coming posedge must carry the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out0_vld && out0_rdy) begin
                if (q0.size() == 0) check("out0_unexpected", 300'(out0_vld), 300'(0));
                else check("out0_beat", {out0_opcode, out0_data, out0_sideband, out0_src_id,
                                         out0_tgt_id}, q0.pop_front());
            end
            if (out1_vld && out1_rdy) begin
                if (q1.size() == 0) check("out1_unexpected", 300'(out1_vld), 300'(0));
                else check("out1_beat", {out1_opcode, out1_data, out1_sideband, out1_src_id,
                                         out1_tgt_id}, q1.pop_front());
            end
        end
    end

    task automatic set_beat(input logic [3:0] tgt, input logic [3:0] src,
                            input logic [255:0] data, input logic [9:0] sb, input logic op);
        in_vld      = 1'b1;
        in_tgt_id   = tgt;
        in_src_id   = src;
        in_data     = data;
        in_sideband = sb;
        in_opcode   = op;
    endtask

    // Present a beat from posedge+1, wait (bounded) for in_rdy, record expectation, retire it.
    task automatic drive(input logic [3:0] tgt, input logic [3:0] src, input logic [255:0] data,
                         input logic [9:0] sb, input logic op, output int waits);
        set_beat(tgt, src, data, sb, op);
        waits = 0;
        @(negedge clk);
        while (!in_rdy && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_rdy) begin
            check("accept_timeout", 300'(in_rdy), 300'(1));
            in_vld = 1'b0;
            return;
        end
        if (tgt == 4'd0) q0.push_back({op, data, sb, src, tgt});
        else if (tgt == 4'd1) q1.push_back({op, data, sb, src, tgt});
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w, wsum, c0;
        logic [255:0] d;

        rst_n = 1'b0; in_vld = 1'b0; in_opcode = 1'b0; in_data = '0; in_sideband = '0;
        in_src_id = '0; in_tgt_id = '0; out0_rdy = 1'b1; out1_rdy = 1'b1; err_clr = 1'b0;
        #2;
        check("rst_out0_vld", 300'(out0_vld), 300'(0));
        check("rst_out1_vld", 300'(out1_vld), 300'(0));
        check("rst_out0_data", 300'(out0_data), 300'(0));
        check("rst_err", {drop_cnt, err_vld, err_src_id, err_tgt_id}, 300'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Route basic
        d = {32{8'hA5}};
        drive(4'd0, 4'd3, d, 10'h155, 1'b1, w);
        check("route_lat_out0", 300'(out0_vld), 300'(1));
        check("route_rdy0", 300'(w), 300'(0));
        d = {32{8'h5A}};
        drive(4'd1, 4'd4, d, 10'h0AA, 1'b0, w);
        check("route_lat_out1", {out1_vld, out0_vld}, 300'(2'b10));
        check("route_rdy1", 300'(w), 300'(0));
        idle(3);

        // Backpressure
        out0_rdy = 1'b0;
        drive(4'd0, 4'd1, {8{32'h1111_0001}}, 10'd1, 1'b0, w);
        drive(4'd0, 4'd1, {8{32'h1111_0002}}, 10'd2, 1'b1, w);
        set_beat(4'd0, 4'd1, {8{32'h1111_0003}}, 10'd3, 1'b0);
        @(negedge clk);
        check("bp_stall", 300'(in_rdy), 300'(0));
        check("bp_hold_head", 300'(out0_data), 300'({8{32'h1111_0001}}));
        @(posedge clk); #1;
        out0_rdy = 1'b1;
        @(negedge clk);
        check("bp_still_full", 300'(in_rdy), 300'(0));
        @(posedge clk); #1;
        drive(4'd0, 4'd1, {8{32'h1111_0003}}, 10'd3, 1'b0, w);
        check("bp_third_accept", 300'(w), 300'(0));
        idle(4);

        // Streaming
        wsum = 0;
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            drive(4'd0, 4'(i), {8{i}}, 10'(i * 7), i[0], w);
            wsum += w;
        end
        check("stream_cycles", 300'(cyc - c0), 300'(16));
        check("stream_stalls", 300'(wsum), 300'(0));
        idle(4);

        // Head-of-line blocking
        out0_rdy = 1'b0;
        drive(4'd0, 4'd6, {8{32'hB0B0_0001}}, 10'd11, 1'b0, w);
        drive(4'd0, 4'd6, {8{32'hB0B0_0002}}, 10'd12, 1'b0, w);
        set_beat(4'd0, 4'd6, {8{32'hB0B0_0003}}, 10'd13, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("hol_in_rdy", 300'(in_rdy), 300'(0));
            check("hol_out1_vld", 300'(out1_vld), 300'(0));
        end
        @(posedge clk); #1;
        out0_rdy = 1'b1;
        drive(4'd0, 4'd6, {8{32'hB0B0_0003}}, 10'd13, 1'b1, w);
        drive(4'd1, 4'd6, {8{32'hC1C1_0001}}, 10'd14, 1'b0, w);
        check("hol_out1_after", 300'(out1_vld), 300'(1));
        idle(4);

        // Drop / error
        drive(4'd7, 4'd2, {8{32'hDEAD_0007}}, 10'd0, 1'b0, w);
        drive(4'd9, 4'd5, {8{32'hDEAD_0009}}, 10'd0, 1'b0, w);
        check("drop_no_out", {out0_vld, out1_vld}, 300'(0));
        check("drop_cnt2", 300'(drop_cnt), 300'(2));
        check("drop_err", {err_vld, err_src_id, err_tgt_id}, {1'b1, 4'd2, 4'd7});
        err_clr = 1'b1;
        drive(4'd9, 4'd5, {8{32'hDEAD_0009}}, 10'd0, 1'b0, w);
        err_clr = 1'b0;
        check("clr_drop_cnt", 300'(drop_cnt), 300'(1));
        check("clr_drop_err", {err_vld, err_src_id, err_tgt_id}, {1'b1, 4'd5, 4'd9});
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("clr_only", {drop_cnt, err_vld}, 300'(0));
        for (int i = 0; i < 300; i++) drive(4'd7, 4'd2, '0, 10'd0, 1'b0, w);
        check("drop_sat", 300'(drop_cnt), 300'(8'hFF));
        check("drop_sat_err", {err_vld, err_src_id, err_tgt_id}, {1'b1, 4'd2, 4'd7});

        // Reset mid-operation
        out0_rdy = 1'b0;
        out1_rdy = 1'b0;
        drive(4'd0, 4'd8, {8{32'hF00D_0001}}, 10'd1, 1'b0, w);
        drive(4'd0, 4'd8, {8{32'hF00D_0002}}, 10'd2, 1'b0, w);
        drive(4'd1, 4'd8, {8{32'hF00D_0003}}, 10'd3, 1'b0, w);
        drive(4'd1, 4'd8, {8{32'hF00D_0004}}, 10'd4, 1'b0, w);
        check("pre_rst_vld", {out0_vld, out1_vld}, 300'(2'b11));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vld", {out0_vld, out1_vld}, 300'(0));
        check("arst_data", {out0_data, out1_data}, 300'(0));
        check("arst_err", {drop_cnt, err_vld, err_src_id, err_tgt_id}, 300'(0));
        q0.delete();
        q1.delete();
        out0_rdy = 1'b1;
        out1_rdy = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(4'd1, 4'd9, {32{8'h3C}}, 10'h3FF, 1'b1, w);
        check("post_rst_lat", 300'(out1_vld), 300'(1));
        idle(4);

        check("q0_drained", 300'(q0.size()), 300'(0));
        check("q1_drained", 300'(q1.size()), 300'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
